date_counter: RTL and testbench

DATE_COUNTER -- requirements
Module: date_counter

---
 rtl/date_counter.sv | 102 ++++++++++
 tb/tb_date_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/date_counter.sv
// Calendar date register (day/month/year-in-century) advanced by day_tick and
// loaded by set_load, with combinational BCD views and registered event pulses.
module date_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       day_tick,
  input  logic       set_load,
  input  logic [4:0] set_day,
  input  logic [3:0] set_month,
  input  logic [6:0] set_year,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic       year_divisible_by_4,
  output logic [7:0] day_bcd,
  output logic [7:0] month_bcd,
  output logic [7:0] year_bcd,
  output logic       century_wrap,
  output logic       set_err
);

  // Event semantics: day_tick and set_load are level-sampled every cycle (no
  // handshake); set_load wins over day_tick, and a low rst_n discards both.

  function automatic logic [4:0] dim(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = leap ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  endfunction

  // Repeated subtraction is enough: every value here is at most 99.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [6:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int k = 0; k < 9; k++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    to_bcd = {tens, rem[3:0]};
  endfunction

  logic       leap;
  logic [4:0] cur_dim;
  logic       load_ok;

  assign leap    = (year[1:0] == 2'd0);
  assign cur_dim = dim(month, leap);
  assign load_ok = (set_month >= 4'd1) && (set_month <= 4'd12) &&
                   (set_year <= 7'd99) && (set_day != 5'd0) &&
                   (set_day <= dim(set_month, set_year[1:0] == 2'd0));

  assign year_divisible_by_4 = leap;
  assign day_bcd             = to_bcd({2'b00, day});
  assign month_bcd           = to_bcd({3'b000, month});
  assign year_bcd            = to_bcd(year);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      day          <= 5'd1;
      month        <= 4'd1;
      year         <= 7'd0;
      century_wrap <= 1'b0;
      set_err      <= 1'b0;
    end else begin
      century_wrap <= 1'b0;
      set_err      <= 1'b0;
      if (set_load) begin
        if (load_ok) begin
          day   <= set_day;
          month <= set_month;
          year  <= set_year;
        end else begin
          set_err <= 1'b1;
        end
      end else if (day_tick) begin
        if (day < cur_dim) begin
          day <= day + 5'd1;
        end else begin
          day <= 5'd1;
          if (month < 4'd12) begin
            month <= month + 4'd1;
          end else begin
            month <= 4'd1;
            if (year < 7'd99) begin
              year <= year + 7'd1;
            end else begin
              year         <= 7'd0;
              century_wrap <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_date_counter.sv
// Bench for date_counter: calendar-arithmetic reference model feeding an expected
// queue, per-cycle comparison, directed calendar cases and a randomized run.
module tb_date_counter;

  logic       clk;
  logic       rst_n;
  logic       day_tick;
  logic       set_load;
  logic [4:0] set_day;
  logic [3:0] set_month;
  logic [6:0] set_year;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic       year_divisible_by_4;
  logic [7:0] day_bcd;
  logic [7:0] month_bcd;
  logic [7:0] year_bcd;
  logic       century_wrap;
  logic       set_err;

  date_counter dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .day_tick            (day_tick),
    .set_load            (set_load),
    .set_day             (set_day),
    .set_month           (set_month),
    .set_year            (set_year),
    .day                 (day),
    .month               (month),
    .year                (year),
    .year_divisible_by_4 (year_divisible_by_4),
    .day_bcd             (day_bcd),
    .month_bcd           (month_bcd),
    .year_bcd            (year_bcd),
    .century_wrap        (century_wrap),
    .set_err             (set_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // reference model: plain calendar arithmetic
  int month_len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  function automatic int mdays(input int m, input int y);
    if (m < 1 || m > 12) return 0;
    if (m == 2 && (y % 4) == 0) return 29;
    return month_len[m-1];
  endfunction

  function automatic int bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  int md = 1, mm = 1, my = 0;
  logic [17:0] exp_q[$];

  always @(posedge clk) begin
    int cw, er;
    cw = 0;
    er = 0;
    if (!rst_n) begin
      md = 1; mm = 1; my = 0;
    end else if (set_load) begin
      if (set_year <= 99 && int'(set_day) >= 1 &&
          int'(set_day) <= mdays(int'(set_month), int'(set_year))) begin
        md = int'(set_day); mm = int'(set_month); my = int'(set_year);
      end else begin
        er = 1;
      end
    end else if (day_tick) begin
      md++;
      if (md > mdays(mm, my)) begin
        md = 1;
        mm++;
        if (mm > 12) begin
          mm = 1;
          my++;
          if (my > 99) begin
            my = 0;
            cw = 1;
          end
        end
      end
    end
    exp_q.push_back({5'(md), 4'(mm), 7'(my), 1'(cw), 1'(er)});
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [17:0] e;
      int ed, em, ey;
      e  = exp_q.pop_front();
      ed = int'(e[17:13]);
      em = int'(e[12:9]);
      ey = int'(e[8:2]);
      chk("day", int'(day), ed);
      chk("month", int'(month), em);
      chk("year", int'(year), ey);
      chk("century_wrap", int'(century_wrap), int'(e[1]));
      chk("set_err", int'(set_err), int'(e[0]));
      chk("div4", int'(year_divisible_by_4), int'((ey % 4) == 0));
      chk("day_bcd", int'(day_bcd), bcd(ed));
      chk("month_bcd", int'(month_bcd), bcd(em));
      chk("year_bcd", int'(year_bcd), bcd(ey));
    end
  end

  // driver: apply one cycle of inputs, return at the following negedge
  task automatic drive(input logic rn, input logic tk, input logic ld,
                       input int d, input int m, input int y);
    rst_n     = rn;
    day_tick  = tk;
    set_load  = ld;
    set_day   = 5'(d);
    set_month = 4'(m);
    set_year  = 7'(y);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic tick();
    drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic load(input int d, input int m, input int y);
    drive(1'b1, 1'b0, 1'b1, d, m, y);
  endtask

  task automatic lit(input string name, input int d, input int m, input int y);
    chk({name, "_day"}, int'(day), d);
    chk({name, "_month"}, int'(month), m);
    chk({name, "_year"}, int'(year), y);
  endtask

  initial begin
    rst_n = 1'b0; day_tick = 1'b0; set_load = 1'b0;
    set_day = '0; set_month = '0; set_year = '0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 5, 5, 5);
    lit("reset", 1, 1, 0);
    chk("reset_div4", int'(year_divisible_by_4), 1);
    chk("reset_day_bcd", int'(day_bcd), 'h01);
    chk("reset_month_bcd", int'(month_bcd), 'h01);
    chk("reset_year_bcd", int'(year_bcd), 'h00);
    chk("reset_cw", int'(century_wrap), 0);
    chk("reset_err", int'(set_err), 0);

    // leap February
    load(28, 2, 24); lit("leap_load", 28, 2, 24);
    tick();          lit("leap_29", 29, 2, 24);
    tick();          lit("leap_mar", 1, 3, 24);
    // non-leap February
    load(28, 2, 23); tick(); lit("nonleap_mar", 1, 3, 23);
    // century rollover
    load(31, 12, 99);
    chk("y99_bcd", int'(year_bcd), 'h99);
    chk("d31_bcd", int'(day_bcd), 'h31);
    chk("m12_bcd", int'(month_bcd), 'h12);
    tick(); lit("century", 1, 1, 0);
    chk("century_cw", int'(century_wrap), 1);
    chk("century_div4", int'(year_divisible_by_4), 1);
    idle(); chk("century_cw_drop", int'(century_wrap), 0);
    // rejected loads
    load(29, 2, 23); chk("rej1_err", int'(set_err), 1); lit("rej1", 1, 1, 0);
    load(31, 4, 10); chk("rej2_err", int'(set_err), 1); lit("rej2", 1, 1, 0);
    load(5, 13, 10); chk("rej3_err", int'(set_err), 1); lit("rej3", 1, 1, 0);
    load(0, 1, 10);  chk("rej4_err", int'(set_err), 1);
    load(1, 1, 100); chk("rej5_err", int'(set_err), 1);
    idle(); chk("err_drop", int'(set_err), 0);
    // simultaneous load and tick
    drive(1'b1, 1'b1, 1'b1, 15, 6, 50); lit("simul", 15, 6, 50);
    drive(1'b1, 1'b1, 1'b1, 31, 4, 10); lit("simul_rej", 15, 6, 50);
    chk("simul_rej_err", int'(set_err), 1);
    // reset together with a tick
    drive(1'b0, 1'b1, 1'b0, 0, 0, 0); lit("rst_tick", 1, 1, 0);
    // mid-run reset after a full year 00 (366 days)
    for (int i = 0; i < 365; i++) tick();
    lit("day365", 31, 12, 0);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0); lit("midrst", 1, 1, 0);
    tick(); lit("midrst_tick", 2, 1, 0);

    // randomized run, mostly ticks with occasional loads and resets
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3, 3, 3);
      end else if (r < 12) begin
        drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 31),
              $urandom_range(0, 15), $urandom_range(0, 127));
      end else if (r < 20) begin
        load($urandom_range(25, 31), 12, $urandom_range(95, 99));
      end else begin
        drive(1'b1, 1'($urandom_range(0, 3) != 0), 1'b0, 0, 0, 0);
      end
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
